// File: rtl/bus_arbiter_pkg.sv
// Shared types for the round-robin bus arbiter.
//   arb_state_e : arbiter FSM states
//   slot_ctl_t  : per-core latched strobes, target select and access control
//   grant_width : width of the owner index for a given core count (minimum 1)
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  // Address and write data are sized by the arbiter's AW/DW parameters,
  // so they are held in arrays next to this record rather than inside it.
  typedef struct packed {
    logic       le;
    logic       we;
    logic       dram;
    logic [2:0] ctrl;
  } slot_ctl_t;

  function automatic int unsigned grant_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_if.sv
// Core-side and shared-port signals of the round-robin bus arbiter.
//   slave  : arbiter view (takes core requests, drives the shared port)
//   master : environment view (cores plus downstream system)
interface bus_arbiter_rr_if #(
  parameter int unsigned NCORES = 2,
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32
);
  logic [NCORES-1:0]    c_le;
  logic [NCORES-1:0]    c_we;
  logic [NCORES-1:0]    c_dram;
  logic [NCORES-1:0]    c_lock;
  logic [NCORES*AW-1:0] c_addr;
  logic [NCORES*DW-1:0] c_wdata;
  logic [NCORES*3-1:0]  c_ctrl;
  logic [NCORES-1:0]    c_busy;
  logic [NCORES*DW-1:0] c_rdata;

  logic                 m_le;
  logic                 m_we;
  logic                 m_dram;
  logic [AW-1:0]        m_addr;
  logic [DW-1:0]        m_wdata;
  logic [2:0]           m_ctrl;
  logic                 m_busy;
  logic [DW-1:0]        m_rdata;

  modport slave (
    input  c_le, c_we, c_dram, c_lock, c_addr, c_wdata, c_ctrl,
    output c_busy, c_rdata,
    output m_le, m_we, m_dram, m_addr, m_wdata, m_ctrl,
    input  m_busy, m_rdata
  );

  modport master (
    output c_le, c_we, c_dram, c_lock, c_addr, c_wdata, c_ctrl,
    input  c_busy, c_rdata,
    input  m_le, m_we, m_dram, m_addr, m_wdata, m_ctrl,
    output m_busy, m_rdata
  );
endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Round-robin winner selection with lock override.
//   req   : pending request mask
//   last  : current owner index
//   lock  : owner holds the bus; only 'last' may win
//   idx   : selected index (valid only when 'valid' is high)
//   valid : some eligible request exists
module rr_pick #(
  parameter int unsigned N  = 2,
  parameter int unsigned GW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] last,
  input  logic          lock,
  output logic [GW-1:0] idx,
  output logic          valid
);

  always_comb begin
    int unsigned c;
    c     = 0;
    idx   = last;
    valid = 1'b0;
    if (lock) begin
      valid = req[last];
    end else begin
      // Scan last+1 .. last+N so the previous owner has lowest priority.
      for (int unsigned k = 1; k <= N; k++) begin
        c = (int'(last) + k) % N;
        if (!valid && req[c[GW-1:0]]) begin
          idx   = c[GW-1:0];
          valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter sharing one downstream bus port among NCORES cores.
//   CLK, RST_X : clock, asynchronous active-low reset
//   bus        : core request/response signals and the shared port (slave view)
//   grant      : current owner index
//   err        : sticky protocol error (request while busy, m_busy in IDLE)
module bus_arbiter_rr
  import bus_arbiter_pkg::*;
#(
  parameter  int unsigned NCORES = 2,
  parameter  int unsigned AW     = 32,
  parameter  int unsigned DW     = 32,
  localparam int unsigned GW     = grant_width(NCORES)
) (
  input  logic             CLK,
  input  logic             RST_X,
  bus_arbiter_rr_if.slave  bus,
  output logic [GW-1:0]    grant,
  output logic             err
);

  arb_state_e           state;
  slot_ctl_t            slot_ctl   [NCORES];
  logic [AW-1:0]        slot_addr  [NCORES];
  logic [DW-1:0]        slot_wdata [NCORES];
  logic [NCORES-1:0]    pending;
  logic [NCORES-1:0]    busy_q;
  logic [NCORES*DW-1:0] rdata_q;
  logic                 m_le_q;
  logic                 m_we_q;

  logic [NCORES-1:0]    new_req;
  logic                 done;
  logic [GW-1:0]        pick_idx;
  logic                 pick_valid;

  assign new_req = bus.c_le | bus.c_we;
  assign done    = (state == ST_WAIT) && !bus.m_busy;

  rr_pick #(.N(NCORES), .GW(GW)) u_pick (
    .req   (pending),
    .last  (grant),
    .lock  (bus.c_lock[grant]),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign bus.c_busy  = busy_q;
  assign bus.c_rdata = rdata_q;
  assign bus.m_le    = m_le_q;
  assign bus.m_we    = m_we_q;
  assign bus.m_dram  = slot_ctl[grant].dram;
  assign bus.m_ctrl  = slot_ctl[grant].ctrl;
  assign bus.m_addr  = slot_addr[grant];
  assign bus.m_wdata = slot_wdata[grant];

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state   <= ST_IDLE;
      grant   <= '0;
      pending <= '0;
      busy_q  <= '0;
      rdata_q <= '0;
      m_le_q  <= 1'b0;
      m_we_q  <= 1'b0;
      err     <= 1'b0;
      for (int unsigned i = 0; i < NCORES; i++) begin
        slot_ctl[i]   <= '0;
        slot_addr[i]  <= '0;
        slot_wdata[i] <= '0;
      end
    end else begin
      if (done) begin
        busy_q[grant]  <= 1'b0;
        pending[grant] <= 1'b0;
        // Writes leave the last read data in place.
        if (slot_ctl[grant].le) rdata_q[grant*DW +: DW] <= bus.m_rdata;
      end

      // Placed after the completion clear so an owner re-request on its
      // completion edge wins over the clear.
      for (int unsigned i = 0; i < NCORES; i++) begin
        if (new_req[i]) begin
          if (busy_q[i] && !(done && grant == GW'(i))) begin
            err <= 1'b1;
          end else begin
            slot_ctl[i]   <= '{le:   bus.c_le[i],
                               we:   bus.c_we[i],
                               dram: bus.c_dram[i],
                               ctrl: bus.c_ctrl[i*3 +: 3]};
            slot_addr[i]  <= bus.c_addr[i*AW +: AW];
            slot_wdata[i] <= bus.c_wdata[i*DW +: DW];
            pending[i]    <= 1'b1;
            busy_q[i]     <= 1'b1;
          end
        end
      end

      case (state)
        ST_IDLE: begin
          if (bus.m_busy) err <= 1'b1;
          if (pick_valid) begin
            grant  <= pick_idx;
            m_le_q <= slot_ctl[pick_idx].le;
            m_we_q <= slot_ctl[pick_idx].we;
            state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (bus.m_busy) begin
            m_le_q <= 1'b0;
            m_we_q <= 1'b0;
            state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!bus.m_busy) state <= ST_IDLE;
        end
        default: begin
          m_le_q <= 1'b0;
          m_we_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
`timescale 1ns/1ps
module tb_bus_arbiter_rr;
  localparam int unsigned NC = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic       CLK = 1'b0;
  logic       RST_X;
  logic [1:0] grant;
  logic       err;

  bus_arbiter_rr_if #(.NCORES(NC), .AW(AW), .DW(DW)) bus ();

  bus_arbiter_rr #(.NCORES(NC), .AW(AW), .DW(DW)) dut (
    .CLK   (CLK),
    .RST_X (RST_X),
    .bus   (bus),
    .grant (grant),
    .err   (err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int unsigned core;
    logic        le;
    logic        we;
    logic        dram;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  ctrl;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    int unsigned core;
    logic        we;
    logic        dram;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  ctrl;
    logic [31:0] exp_rdata;
  } vec_t;

  exp_t        exp_q[$];
  vec_t        vecs[6];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic        resp_en  = 1'b1;
  logic        mb_resp  = 1'b0;
  logic        mb_main  = 1'b0;

  assign bus.m_busy = mb_resp | mb_main;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h8000_1000) ? 32'hDEAD_BEEF : ((a ^ 32'hA5A5_5A5A) + 32'd7);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic set_req(input int unsigned c, input logic we, input logic dram,
                         input logic [31:0] a, input logic [31:0] wd, input logic [2:0] ctl);
    bus.c_le[c]               = !we;
    bus.c_we[c]               = we;
    bus.c_dram[c]             = dram;
    bus.c_addr[c*AW +: AW]    = a;
    bus.c_wdata[c*DW +: DW]   = wd;
    bus.c_ctrl[c*3 +: 3]      = ctl;
  endtask

  task automatic push_exp(input int unsigned c, input logic we, input logic dram,
                          input logic [31:0] a, input logic [31:0] wd, input logic [2:0] ctl,
                          input logic [31:0] rd);
    exp_t e;
    e = '{core: c, le: !we, we: we, dram: dram, addr: a, wdata: wd, ctrl: ctl, rdata: rd};
    exp_q.push_back(e);
  endtask

  // Requests set up at a negedge are sampled at the next posedge, then dropped.
  task automatic pulse();
    @(posedge CLK);
    @(negedge CLK);
    bus.c_le = '0;
    bus.c_we = '0;
  endtask

  task automatic wait_done(input string name, input int unsigned budget);
    int unsigned n = 0;
    while ((exp_q.size() != 0 || bus.c_busy != '0) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    chk({name, "_drain"}, 64'(exp_q.size()) + 64'(bus.c_busy), 64'd0);
  endtask

  task automatic wait_busy_low(input string name, input int unsigned c, input int unsigned budget);
    int unsigned n = 0;
    while (bus.c_busy[c] && n < budget) begin
      @(negedge CLK);
      n++;
    end
    chk(name, 64'(bus.c_busy[c]), 64'd0);
  endtask

  task automatic wait_strobe(input string name, input int unsigned budget);
    int unsigned n = 0;
    while (!(bus.m_le || bus.m_we) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    chk(name, 64'(bus.m_le | bus.m_we), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_X = 1'b0;
    repeat (2) @(negedge CLK);
    RST_X = 1'b1;
  endtask

  // Downstream system: busy 1 cycle after the strobe, for 3 cycles.
  initial begin : responder
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (resp_en && (bus.m_le || bus.m_we)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          chk("grant",   64'(grant),       64'(e.core));
          chk("m_addr",  64'(bus.m_addr),  64'(e.addr));
          chk("m_le",    64'(bus.m_le),    64'(e.le));
          chk("m_we",    64'(bus.m_we),    64'(e.we));
          chk("m_dram",  64'(bus.m_dram),  64'(e.dram));
          chk("m_ctrl",  64'(bus.m_ctrl),  64'(e.ctrl));
          chk("m_wdata", 64'(bus.m_wdata), 64'(e.wdata));
          @(posedge CLK); #1;
          chk("strobe_held", 64'(bus.m_le | bus.m_we), 64'd1);
          mb_resp = 1'b1;
          @(posedge CLK); #1;
          chk("strobe_drop", 64'(bus.m_le | bus.m_we), 64'd0);
          repeat (2) @(posedge CLK);
          #1;
          mb_resp     = 1'b0;
          bus.m_rdata = mem_fn(e.addr);
          @(posedge CLK); #1;
          chk("c_rdata", 64'(bus.c_rdata[e.core*DW +: DW]), 64'(e.rdata));
          chk("c_busy_clear", 64'(bus.c_busy[e.core]), 64'd0);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vecs[0] = '{core: 0, we: 1'b0, dram: 1'b1, addr: 32'h0000_0100, wdata: 32'h0,
                ctrl: 3'd2, exp_rdata: mem_fn(32'h0000_0100)};
    vecs[1] = '{core: 1, we: 1'b1, dram: 1'b0, addr: 32'h1000_0004, wdata: 32'h1234_5678,
                ctrl: 3'd1, exp_rdata: 32'h0};
    vecs[2] = '{core: 1, we: 1'b0, dram: 1'b0, addr: 32'h1000_0008, wdata: 32'h0,
                ctrl: 3'd2, exp_rdata: mem_fn(32'h1000_0008)};
    vecs[3] = '{core: 1, we: 1'b1, dram: 1'b1, addr: 32'h2000_0000, wdata: 32'hCAFE_F00D,
                ctrl: 3'd0, exp_rdata: mem_fn(32'h1000_0008)};
    vecs[4] = '{core: 3, we: 1'b0, dram: 1'b1, addr: 32'hFFFF_FFFC, wdata: 32'h0,
                ctrl: 3'd2, exp_rdata: mem_fn(32'hFFFF_FFFC)};
    vecs[5] = '{core: 0, we: 1'b1, dram: 1'b0, addr: 32'h0000_0000, wdata: 32'hFFFF_FFFF,
                ctrl: 3'd7, exp_rdata: mem_fn(32'h0000_0100)};

    RST_X       = 1'b0;
    bus.c_le    = '0;
    bus.c_we    = '0;
    bus.c_dram  = '0;
    bus.c_lock  = '0;
    bus.c_addr  = '0;
    bus.c_wdata = '0;
    bus.c_ctrl  = '0;
    bus.m_rdata = '0;
    repeat (2) @(negedge CLK);

    chk("rst_grant",  64'(grant),       64'd0);
    chk("rst_err",    64'(err),         64'd0);
    chk("rst_busy",   64'(bus.c_busy),  64'd0);
    chk("rst_rdata",  bus.c_rdata[63:0], 64'd0);
    chk("rst_strobe", 64'({bus.m_le, bus.m_we}), 64'd0);
    chk("rst_addr",   64'(bus.m_addr),  64'd0);
    RST_X = 1'b1;

    // All four cores at once from grant 0: service order 1,2,3,0.
    @(negedge CLK);
    for (int unsigned i = 0; i < NC; i++) set_req(i, 1'b0, 1'b1, 32'h4000 + 32'(i) * 32'h100, 32'h0, 3'd2);
    push_exp(1, 1'b0, 1'b1, 32'h4100, 32'h0, 3'd2, mem_fn(32'h4100));
    push_exp(2, 1'b0, 1'b1, 32'h4200, 32'h0, 3'd2, mem_fn(32'h4200));
    push_exp(3, 1'b0, 1'b1, 32'h4300, 32'h0, 3'd2, mem_fn(32'h4300));
    push_exp(0, 1'b0, 1'b1, 32'h4000, 32'h0, 3'd2, mem_fn(32'h4000));
    pulse();
    chk("all_busy", 64'(bus.c_busy), 64'hF);
    wait_done("rr4", 200);

    // Single read: strobe appears on the second edge after the request.
    @(negedge CLK);
    set_req(2, 1'b0, 1'b0, 32'h8000_1000, 32'h0, 3'd2);
    push_exp(2, 1'b0, 1'b0, 32'h8000_1000, 32'h0, 3'd2, 32'hDEAD_BEEF);
    pulse();
    chk("no_strobe_edge1", 64'(bus.m_le), 64'd0);
    @(posedge CLK); #1;
    chk("strobe_edge2", 64'(bus.m_le), 64'd1);
    wait_done("single", 50);

    // Table: one transaction at a time from a clean reset.
    do_reset();
    foreach (vecs[i]) begin
      @(negedge CLK);
      set_req(vecs[i].core, vecs[i].we, vecs[i].dram, vecs[i].addr, vecs[i].wdata, vecs[i].ctrl);
      push_exp(vecs[i].core, vecs[i].we, vecs[i].dram, vecs[i].addr, vecs[i].wdata,
               vecs[i].ctrl, vecs[i].exp_rdata);
      pulse();
      wait_done("vec", 50);
    end
    chk("err_clean", 64'(err), 64'd0);

    // Lock: core 1 keeps the bus across two requests while core 3 waits.
    @(negedge CLK);
    bus.c_lock[1] = 1'b1;
    set_req(1, 1'b0, 1'b1, 32'h5000, 32'h0, 3'd2);
    push_exp(1, 1'b0, 1'b1, 32'h5000, 32'h0, 3'd2, mem_fn(32'h5000));
    push_exp(1, 1'b0, 1'b1, 32'h5004, 32'h0, 3'd2, mem_fn(32'h5004));
    push_exp(3, 1'b0, 1'b0, 32'h7000, 32'h0, 3'd2, mem_fn(32'h7000));
    pulse();
    wait_strobe("lock_strobe", 20);
    set_req(3, 1'b0, 1'b0, 32'h7000, 32'h0, 3'd2);
    pulse();
    wait_busy_low("lock_first_done", 1, 50);
    set_req(1, 1'b0, 1'b1, 32'h5004, 32'h0, 3'd2);
    pulse();
    chk("core3_still_pending", 64'(bus.c_busy[3]), 64'd1);
    wait_busy_low("lock_second_done", 1, 50);
    bus.c_lock[1] = 1'b0;
    wait_done("lock", 50);

    // m_busy high while idle flags an error that persists.
    do_reset();
    resp_en = 1'b0;
    @(negedge CLK);
    mb_main = 1'b1;
    @(negedge CLK);
    mb_main = 1'b0;
    chk("err_busy_idle", 64'(err), 64'd1);
    repeat (3) @(negedge CLK);
    chk("err_sticky_idle", 64'(err), 64'd1);
    resp_en = 1'b1;

    // Re-request from busy core 0: error, first transaction unaffected.
    do_reset();
    chk("err_after_reset", 64'(err), 64'd0);
    @(negedge CLK);
    set_req(0, 1'b0, 1'b1, 32'h6000, 32'h0, 3'd2);
    push_exp(0, 1'b0, 1'b1, 32'h6000, 32'h0, 3'd2, mem_fn(32'h6000));
    pulse();
    set_req(0, 1'b0, 1'b0, 32'h6666, 32'h0, 3'd1);
    pulse();
    chk("err_rereq", 64'(err), 64'd1);
    wait_done("rereq", 50);
    chk("err_sticky_rereq", 64'(err), 64'd1);

    // Reset in the middle of WAIT, then a normal transaction.
    resp_en = 1'b0;
    @(negedge CLK);
    set_req(3, 1'b0, 1'b0, 32'h3000, 32'h0, 3'd2);
    pulse();
    wait_strobe("midwait_strobe", 20);
    mb_main = 1'b1;
    repeat (2) @(negedge CLK);
    #2;
    RST_X = 1'b0;
    #1;
    chk("mid_busy",   64'(bus.c_busy),  64'd0);
    chk("mid_grant",  64'(grant),       64'd0);
    chk("mid_err",    64'(err),         64'd0);
    chk("mid_strobe", 64'({bus.m_le, bus.m_we}), 64'd0);
    chk("mid_rdata",  bus.c_rdata[63:0], 64'd0);
    chk("mid_addr",   64'(bus.m_addr),  64'd0);
    mb_main = 1'b0;
    @(negedge CLK);
    RST_X   = 1'b1;
    resp_en = 1'b1;
    @(negedge CLK);
    set_req(1, 1'b0, 1'b1, 32'h9000, 32'h0, 3'd2);
    push_exp(1, 1'b0, 1'b1, 32'h9000, 32'h0, 3'd2, mem_fn(32'h9000));
    pulse();
    wait_done("post_reset", 50);
    repeat (2) @(negedge CLK);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
